// File: rtl/mem_pkg.sv
// Shared definitions for the arb_mux_nx1 slice.
//
// Contents:
//   state_e      - output-register state: StIdle (outValid=0) / StHold (outValid=1)
//   clog2_min1() - ceil(log2(n)), never less than 1; sizes the priority pointer
package mem_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // A 1-wide pointer is kept even for n<=2 so vector declarations stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority-encode.
//
// Searches req_i starting at index ptr_i, then ptr_i+1, ... wrapping from
// Channels-1 back to 0, and reports the first set bit.
//
// Ports:
//   req_i    [Channels-1:0] request vector
//   ptr_i    [PtrW-1:0]     search start index (0..Channels-1)
//   onehot_o [Channels-1:0] one-hot winner, all zero when req_i is zero
//   idx_o    [PtrW-1:0]     binary winner index, zero when req_i is zero
module rr_pick
  import mem_pkg::*;
#(
  parameter int unsigned Channels = 4,
  parameter int unsigned PtrW     = clog2_min1(Channels)
) (
  input  logic [Channels-1:0] req_i,
  input  logic [PtrW-1:0]     ptr_i,
  output logic [Channels-1:0] onehot_o,
  output logic [PtrW-1:0]     idx_o
);

  logic              found;
  logic [PtrW-1:0]   cand;
  int unsigned       sum;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = '0;
    sum      = 0;
    for (int unsigned k = 0; k < Channels; k++) begin
      // ptr_i < Channels, so one conditional subtract performs the wrap.
      sum = 32'(ptr_i) + k;
      if (sum >= Channels) sum = sum - Channels;
      cand = PtrW'(sum);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// N-to-1 arbitrated multiplexer with a single registered output word.
//
// Each cycle in which the output register is free (empty, or being drained by
// outReady) and at least one channel requests, one channel is picked, its data
// slice is latched into y, and a one-cycle ack pulse goes back to that channel.
// Back-to-back captures sustain one word per cycle.
//
// Configuration:
//   ARB_MUX_NX1_RR_EN defined   - round-robin: search starts one past last winner
//   ARB_MUX_NX1_RR_EN undefined - fixed priority: lowest index always wins
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous, active-high
//   req       [channels-1:0]      per-channel request
//   inputVal  [size*channels-1:0] packed channel data, channel i at [size*i +: size]
//   outReady  downstream accepts y this cycle when outValid is high
//   y         [size-1:0]          registered selected data
//   outValid  registered, y holds a pending word
//   grant     [channels-1:0]      registered one-hot source of y, zero when idle
//   ack       [channels-1:0]      combinational one-hot capture pulse
module arb_mux_nx1
  import mem_pkg::*;
#(
  parameter int unsigned size     = 8,
  parameter int unsigned channels = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [channels-1:0]      req,
  input  logic [size*channels-1:0] inputVal,
  input  logic                     outReady,
  output logic [size-1:0]          y,
  output logic                     outValid,
  output logic [channels-1:0]      grant,
  output logic [channels-1:0]      ack
);

  localparam int unsigned PtrW = clog2_min1(channels);

  state_e                state_q;
  logic [size-1:0]       y_q;
  logic [channels-1:0]   grant_q;
  logic [PtrW-1:0]       ptr;
  logic [channels-1:0]   win_oh;
  logic [PtrW-1:0]       win_idx;
  logic [size-1:0]       sel_data;
  logic                  capture;

`ifdef ARB_MUX_NX1_RR_EN
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;

  // Next search start is one past the winner, wrapping at the last channel.
  always_comb begin
    if (win_idx == PtrW'(channels - 1)) ptr_d = '0;
    else                                ptr_d = win_idx + PtrW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)        ptr_q <= '0;
    else if (capture) ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  rr_pick #(
    .Channels (channels),
    .PtrW     (PtrW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr),
    .onehot_o (win_oh),
    .idx_o    (win_idx)
  );

  // The output register is free when empty or when its word leaves this cycle.
  assign capture = !reset && ((state_q == StIdle) || outReady) && (|req);
  assign ack     = capture ? win_oh : '0;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < channels; i++) begin
      if (win_idx == PtrW'(i)) sel_data = inputVal[i*size +: size];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      y_q     <= '0;
      grant_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            state_q <= StHold;
            y_q     <= sel_data;
            grant_q <= win_oh;
          end
        end
        StHold: begin
          if (capture) begin
            y_q     <= sel_data;
            grant_q <= win_oh;
          end else if (outReady) begin
            // Drained with nobody waiting: y keeps its last value.
            state_q <= StIdle;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign y        = y_q;
  assign outValid = (state_q == StHold);
  assign grant    = grant_q;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Self-checking bench for arb_mux_nx1 (size=8, channels=4).
// Expected captures are pushed to a scoreboard when stimulus is applied and
// popped when the registered output appears one cycle later.
module tb_arb_mux_nx1;

  localparam int unsigned Size = 8;
  localparam int unsigned Ch   = 4;
`ifdef ARB_MUX_NX1_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [Ch-1:0]     req;
  logic [Size*Ch-1:0] inputVal;
  logic              outReady;
  logic [Size-1:0]   y;
  logic              outValid;
  logic [Ch-1:0]     grant;
  logic [Ch-1:0]     ack;

  arb_mux_nx1 #(
    .size     (Size),
    .channels (Ch)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .inputVal (inputVal),
    .outReady (outReady),
    .y        (y),
    .outValid (outValid),
    .grant    (grant),
    .ack      (ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [Size-1:0] y;
    logic [Ch-1:0]   g;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  // Reference model state
  logic              m_valid = 1'b0;
  logic [Size-1:0]   m_y     = '0;
  logic [Ch-1:0]     m_grant = '0;
  int                m_ptr   = 0;
  logic              m_cap   = 1'b0;
  int                m_w     = 0;
  logic [Ch-1:0]     m_ack   = '0;
  logic              m_rst   = 1'b0;
  logic [Size*Ch-1:0] m_data = '0;

  function automatic int pick(input logic [Ch-1:0] r, input int p);
    for (int k = 0; k < Ch; k++) begin
      if (r[(p + k) % Ch]) return (p + k) % Ch;
    end
    return 0;
  endfunction

  // Drive one cycle of stimulus at the falling edge and predict ack/capture.
  task automatic apply(input logic [Ch-1:0] r, input logic [Size*Ch-1:0] d,
                       input logic rdy, input logic rst);
    @(negedge clk);
    req = r; inputVal = d; outReady = rdy; reset = rst;
    m_rst  = rst;
    m_data = d;
    m_cap  = !rst && (!m_valid || rdy) && (r != '0);
    m_ack  = '0;
    if (m_cap) begin
      m_w = pick(r, RrEn ? m_ptr : 0);
      m_ack[m_w] = 1'b1;
      e.y = d[m_w*Size +: Size];
      e.g = m_ack;
      sb.push_back(e);
    end
    #1;
  endtask

  // Advance through the rising edge and update the model's registered state.
  task automatic tick();
    @(posedge clk);
    if (m_rst) begin
      m_valid = 1'b0; m_y = '0; m_grant = '0; m_ptr = 0;
    end else if (m_cap) begin
      m_valid = 1'b1; m_y = m_data[m_w*Size +: Size]; m_grant = m_ack;
      m_ptr = (m_w + 1) % Ch;
    end else if (m_valid && outReady) begin
      m_valid = 1'b0; m_grant = '0;
    end
    #1;
  endtask

  task automatic test_reset();
    apply('0, '0, 1'b0, 1'b1);
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    tick();
    n_vec++; if (outValid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", outValid); end
    n_vec++; if (y !== 8'h00) begin n_err++; $display("FAIL reset_y got=%h exp=00", y); end
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", grant); end
  endtask

  task automatic test_capture();
    apply(4'b0100, 32'h44332211, 1'b1, 1'b0);
    n_vec++; if (ack !== 4'b0100) begin n_err++; $display("FAIL cap_ack got=%b exp=0100", ack); end
    tick();
    n_vec++; if (outValid !== 1'b1) begin n_err++; $display("FAIL cap_valid got=%b exp=1", outValid); end
    n_vec++; if (y !== 8'h33 || grant !== 4'b0100) begin
      n_err++; $display("FAIL cap_word got=%h/%b exp=33/0100", y, grant);
    end
    e = sb.pop_front();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      apply(4'b0011, 32'hD4C3B2A1, 1'b0, 1'b0);
      n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL stall_ack[%0d] got=%b exp=0000", i, ack); end
      tick();
      n_vec++; if (y !== 8'h33 || grant !== 4'b0100 || outValid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d] got=%h/%b/%b exp=33/0100/1", i, y, grant, outValid);
      end
    end
    apply(4'b0011, 32'hD4C3B2A1, 1'b1, 1'b0);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL stall_release_ack got=%b exp=0001", ack); end
    tick();
    n_vec++; if (sb.size() == 0) begin n_err++; $display("FAIL stall_sb got=empty exp=entry"); end
    else begin
      e = sb.pop_front();
      if (y !== e.y || grant !== e.g || y !== 8'hA1) begin
        n_err++; $display("FAIL stall_release got=%h/%b exp=%h/%b", y, grant, e.y, e.g);
      end
    end
    apply('0, '0, 1'b1, 1'b0);
    tick();
    n_vec++; if (outValid !== 1'b0 || grant !== 4'b0000 || y !== 8'hA1) begin
      n_err++; $display("FAIL drain got=%b/%b/%h exp=0/0000/a1", outValid, grant, y);
    end
  endtask

  task automatic test_back_to_back();
    logic [Ch-1:0] exp_all [5];
    logic [Ch-1:0] exp_alt [4];
`ifdef ARB_MUX_NX1_RR_EN
    exp_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_alt = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
    exp_all = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_alt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif
    apply('0, '0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(4'b1111, 32'h8877_6655 + 32'(i), 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      n_vec++; if (grant !== exp_all[i] || grant !== e.g || y !== e.y || outValid !== 1'b1) begin
        n_err++; $display("FAIL b2b_all[%0d] got=%b/%h/%b exp=%b/%h/1", i, grant, y, outValid, exp_all[i], e.y);
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply(4'b1010, 32'hCAFE_0000 + 32'(i * 3), 1'b1, 1'b0);
      tick();
      e = sb.pop_front();
      n_vec++; if (grant !== exp_alt[i] || grant !== e.g || y !== e.y) begin
        n_err++; $display("FAIL b2b_alt[%0d] got=%b/%h exp=%b/%h", i, grant, y, exp_alt[i], e.y);
      end
    end
    apply('0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset_hold();
    apply(4'b0100, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    e = sb.pop_front();
    apply(4'b1111, 32'h1234_5678, 1'b0, 1'b1);
    n_vec++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rsthold_ack got=%b exp=0000", ack); end
    tick();
    n_vec++; if (outValid !== 1'b0 || y !== 8'h00 || grant !== 4'b0000) begin
      n_err++; $display("FAIL rsthold_clear got=%b/%h/%b exp=0/00/0000", outValid, y, grant);
    end
    apply(4'b1001, 32'h9900_0077, 1'b1, 1'b0);
    n_vec++; if (ack !== 4'b0001) begin n_err++; $display("FAIL rsthold_ack2 got=%b exp=0001", ack); end
    tick();
    e = sb.pop_front();
    n_vec++; if (grant !== 4'b0001 || y !== 8'h77) begin
      n_err++; $display("FAIL rsthold_grant got=%b/%h exp=0001/77", grant, y);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply(Ch'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0));
      n_vec++; if (ack !== m_ack) begin n_err++; $display("FAIL rnd_ack[%0d] got=%b exp=%b", i, ack, m_ack); end
      tick();
      n_vec++; if (outValid !== m_valid) begin
        n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, outValid, m_valid);
      end
      if (m_cap) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rnd_sb[%0d] got=empty exp=entry", i); end
        else begin
          e = sb.pop_front();
          if (y !== e.y || grant !== e.g) begin
            n_err++; $display("FAIL rnd_word[%0d] got=%h/%b exp=%h/%b", i, y, grant, e.y, e.g);
          end
        end
      end else begin
        n_vec++; if (y !== m_y || grant !== m_grant) begin
          n_err++; $display("FAIL rnd_hold[%0d] got=%h/%b exp=%h/%b", i, y, grant, m_y, m_grant);
        end
      end
    end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    reset = 1'b1; req = '0; inputVal = '0; outReady = 1'b0;
    test_reset();
    test_capture();
    test_stall();
    test_back_to_back();
    test_reset_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
